uart_rx_cfg: RTL and testbench

Parametrised UART receiver; successor to the fixed 8N1 receiver. Supports 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits. Each bit is recovered by 3-sample majority vote, and parity/framing errors are flagged. Sits between the board RX pin and the command/packet parser, on the single system clock.

---
 rtl/uart_rx_cfg.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/even/odd parity, 1 or 2 stop bits, 3-sample
// majority vote per bit. Define UART_RX_CFG_BREAK_DET_EN to enable break detection on o_Break.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);
  localparam logic [15:0] HalfCnt   = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LastCnt   = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LastData  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LastStop  = 4'(STOP_BITS - 1);
  localparam bit          HasParity = (PARITY_MODE != 0);
  localparam bit          OddParity = (PARITY_MODE == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, hist_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 par_pend_q, par_pend_d, frm_pend_q, frm_pend_d;
  logic                 dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 rx_s, vote, window_end, exp_par, frame_bad;

  assign rx_s       = sync_q[1];
  // hist_q holds rx_s from the two previous cycles, so vote covers the last 3 counts.
  assign vote       = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign window_end = (cnt_q == LastCnt);
  assign exp_par    = (^shift_q) ^ OddParity;
  assign frame_bad  = frm_pend_q | ~vote;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    dv_d       = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    case (state_q)
      StIdle: begin
        cnt_d      = '0;
        idx_d      = '0;
        par_pend_d = 1'b0;
        frm_pend_d = 1'b0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          state_d = vote ? StIdle : StData;
        end
      end
      StData: begin
        if (window_end) begin
          cnt_d = '0;
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (idx_q == 4'(i)) shift_d[i] = vote;
          end
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = HasParity ? StParity : StStop;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (window_end) begin
          cnt_d      = '0;
          par_pend_d = HasParity && (vote != exp_par);
          state_d    = StStop;
        end
      end
      StStop: begin
        if (window_end) begin
          cnt_d = '0;
          if (idx_q == LastStop) begin
            dv_d    = 1'b1;
            data_d  = shift_q;
            perr_d  = par_pend_q;
            ferr_d  = frame_bad;
            state_d = frame_bad ? StWaitHigh : StIdle;
          end else begin
            frm_pend_d = frame_bad;
            idx_d      = idx_q + 4'd1;
          end
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync_q     <= 2'b11;
      hist_q     <= 2'b11;
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], i_Rx_Serial};
      hist_q     <= {hist_q[0], rx_s};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_pend_q <= par_pend_d;
      frm_pend_q <= frm_pend_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef UART_RX_CFG_BREAK_DET_EN
  // zero_q stays set only while every voted bit of the frame has been 0.
  logic zero_q, zero_d, brk_q, brk_d;

  always_comb begin
    zero_d = zero_q;
    brk_d  = brk_q;
    if (state_q == StIdle) zero_d = 1'b1;
    else if (window_end && vote) zero_d = 1'b0;
    if (dv_d) brk_d = zero_q & ~vote;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      zero_q <= 1'b1;
      brk_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      brk_q  <= brk_d;
    end
  end

  assign o_Break = brk_q;
`else
  assign o_Break = 1'b0;
`endif

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Data    = data_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Busy       = (state_q != StIdle) | dv_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 7E2, 8O1) at 16 clocks per bit, scoreboarded
// against expected frames pushed as stimulus is driven.
module tb_uart_rx_cfg;
  localparam int Cpb  = 16;
  localparam int Half = (Cpb - 1) / 2;
`ifdef UART_RX_CFG_BREAK_DET_EN
  localparam bit BrkEn = 1'b1;
`else
  localparam bit BrkEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  dut;
    logic [31:0] cyc;
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    logic        brk;
    logic        busy;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx, dv, busy, perr, ferr, brk;
  logic [7:0] data0, data2;
  logic [6:0] data1;
  int         cyc = 0;
  int         total = 0;
  int         passes = 0;
  rec_t       exp_q[$];
  rec_t       obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Data(data0),
    .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Break(brk[0]), .o_Busy(busy[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_7e2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Data(data1),
    .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Break(brk[1]), .o_Busy(busy[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Data(data2),
    .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Break(brk[2]), .o_Busy(busy[2]));

  function automatic int dbits_of(input int d);
    return (d == 1) ? 7 : 8;
  endfunction
  function automatic int pmode_of(input int d);
    return d;
  endfunction
  function automatic int nstop_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction
  function automatic logic [8:0] data_of(input int d);
    case (d)
      0:       return {1'b0, data0};
      1:       return {2'b00, data1};
      default: return {1'b0, data2};
    endcase
  endfunction

  // Capture every DV pulse; the test tasks compare these against exp_q.
  always @(negedge clk) begin
    rec_t r;
    for (int d = 0; d < 3; d++) begin
      if (dv[d] === 1'b1) begin
        r.dut  = 4'(d);
        r.cyc  = cyc;
        r.data = data_of(d);
        r.perr = perr[d];
        r.ferr = ferr[d];
        r.brk  = brk[d];
        r.busy = busy[d];
        obs_q.push_back(r);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame and pushes its expected result; glitch_pos inverts that frame bit
  // for one cycle at its centre.
  task automatic send_frame(input int d, input logic [8:0] data, input bit flip_par,
                            input bit stop_low, input int glitch_pos);
    logic bits[$];
    rec_t e;
    logic par;
    int   nb = dbits_of(d);
    int   pm = pmode_of(d);
    par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(data[i]);
      par = par ^ data[i];
    end
    if (pm != 0) bits.push_back(par ^ (pm == 2) ^ flip_par);
    for (int i = 0; i < nstop_of(d); i++) bits.push_back(~stop_low);
    e.dut  = 4'(d);
    e.cyc  = cyc + 2 + Half + (bits.size() - 1) * Cpb + 2;
    e.data = data;
    e.perr = (pm != 0) && flip_par;
    e.ferr = stop_low;
    e.brk  = 1'b0;
    e.busy = 1'b1;
    exp_q.push_back(e);
    for (int b = 0; b < bits.size(); b++) begin
      rx[d] = bits[b];
      if (b == glitch_pos) begin
        wait_cyc(7);
        rx[d] = ~bits[b];
        wait_cyc(1);
        rx[d] = bits[b];
        wait_cyc(Cpb - 8);
      end else begin
        wait_cyc(Cpb);
      end
    end
    rx[d] = ~stop_low;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 3'b111;
    wait_cyc(3);
    @(negedge clk);
    total++;
    if ({dv, busy, perr, ferr, brk} !== 15'd0 || data0 !== 8'd0 || data1 !== 7'd0 ||
        data2 !== 8'd0)
      $display("FAIL reset_outputs: got dv %b busy %b perr %b ferr %b brk %b data %h/%h/%h, required all 0",
               dv, busy, perr, ferr, brk, data0, data1, data2);
    else passes++;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_basic_8n1();
    rec_t e, o;
    fork
      send_frame(0, 9'h0A5, 1'b0, 1'b0, -1);
      begin
        wait_cyc(2);
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b0) $display("FAIL busy_at_t0: got %b, required 0", busy[0]);
        else passes++;
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b1) $display("FAIL busy_after_t0: got %b, required 1", busy[0]);
        else passes++;
      end
    join
    wait_cyc(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL basic_frame: got no DV, required data %h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL basic_frame: got cyc %0d data %h flags %b, required cyc %0d data %h flags %b",
                              o.cyc, o.data, {o.perr, o.ferr, o.brk, o.busy},
                              e.cyc, e.data, {e.perr, e.ferr, e.brk, e.busy});
        else passes++;
      end
    end
    total++;
    if (obs_q.size() != 0 || busy[0] !== 1'b0) begin
      $display("FAIL basic_after: got %0d extra DV busy %b, required 0 and 0", obs_q.size(), busy[0]);
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_parity_7e2();
    rec_t e, o;
    send_frame(1, 9'h03C, 1'b0, 1'b0, -1);
    wait_cyc(4);
    send_frame(1, 9'h03C, 1'b1, 1'b0, -1);
    wait_cyc(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL parity_frame: got no DV, required data %h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL parity_frame: got cyc %0d data %h flags %b, required cyc %0d data %h flags %b",
                              o.cyc, o.data, {o.perr, o.ferr, o.brk, o.busy},
                              e.cyc, e.data, {e.perr, e.ferr, e.brk, e.busy});
        else passes++;
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      $display("FAIL parity_extra_dv: got %0d, required 0", obs_q.size());
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_frame_err_8o1();
    rec_t e, o;
    send_frame(2, 9'h055, 1'b0, 1'b1, -1);
    wait_cyc(200);
    total++;
    if (busy[2] !== 1'b1) $display("FAIL wait_high_busy: got %b, required 1", busy[2]);
    else passes++;
    rx[2] = 1'b1;
    wait_cyc(8);
    total++;
    if (busy[2] !== 1'b0) $display("FAIL wait_high_exit: got busy %b, required 0", busy[2]);
    else passes++;
    send_frame(2, 9'h012, 1'b0, 1'b0, -1);
    wait_cyc(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL frame_err_frame: got no DV, required data %h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL frame_err_frame: got cyc %0d data %h flags %b, required cyc %0d data %h flags %b",
                              o.cyc, o.data, {o.perr, o.ferr, o.brk, o.busy},
                              e.cyc, e.data, {e.perr, e.ferr, e.brk, e.busy});
        else passes++;
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      $display("FAIL frame_err_extra_dv: got %0d, required 0", obs_q.size());
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    rx[0] = 1'b0;
    wait_cyc(3);
    rx[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy[0] === 1'b1) busy_cnt++;
    end
    total++;
    if (busy_cnt != Half + 1 || obs_q.size() != 0) begin
      $display("FAIL start_glitch: got busy cycles %0d DV %0d, required %0d and 0",
               busy_cnt, obs_q.size(), Half + 1);
      obs_q.delete();
    end else passes++;
    wait_cyc(1);
  endtask

  task automatic test_majority();
    rec_t e, o;
    send_frame(0, 9'h0FF, 1'b0, 1'b0, 4);
    wait_cyc(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL majority_frame: got no DV, required data %h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL majority_frame: got cyc %0d data %h flags %b, required cyc %0d data %h flags %b",
                              o.cyc, o.data, {o.perr, o.ferr, o.brk, o.busy},
                              e.cyc, e.data, {e.perr, e.ferr, e.brk, e.busy});
        else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    send_frame(0, 9'h03C, 1'b0, 1'b0, -1);
    send_frame(0, 9'h0C3, 1'b0, 1'b0, -1);
    send_frame(0, 9'h001, 1'b0, 1'b0, -1);
    wait_cyc(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL b2b_frame: got no DV, required data %h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_frame: got cyc %0d data %h flags %b, required cyc %0d data %h flags %b",
                              o.cyc, o.data, {o.perr, o.ferr, o.brk, o.busy},
                              e.cyc, e.data, {e.perr, e.ferr, e.brk, e.busy});
        else passes++;
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      $display("FAIL b2b_extra_dv: got %0d, required 0", obs_q.size());
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_break();
    rec_t e, o;
    e.dut  = 4'd0;
    e.cyc  = cyc + 2 + Half + 9 * Cpb + 2;
    e.data = 9'h000;
    e.perr = 1'b0;
    e.ferr = 1'b1;
    e.brk  = BrkEn;
    e.busy = 1'b1;
    exp_q.push_back(e);
    rx[0] = 1'b0;
    wait_cyc(12 * Cpb);
    total++;
    if (busy[0] !== 1'b1) $display("FAIL break_hold_busy: got %b, required 1", busy[0]);
    else passes++;
    rx[0] = 1'b1;
    wait_cyc(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL break_frame: got no DV, required data %h", e.data);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL break_frame: got cyc %0d data %h flags %b, required cyc %0d data %h flags %b",
                              o.cyc, o.data, {o.perr, o.ferr, o.brk, o.busy},
                              e.cyc, e.data, {e.perr, e.ferr, e.brk, e.busy});
        else passes++;
      end
    end
    total++;
    if (obs_q.size() != 0 || busy[0] !== 1'b0) begin
      $display("FAIL break_after: got %0d extra DV busy %b, required 0 and 0", obs_q.size(), busy[0]);
      obs_q.delete();
    end else passes++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] byte_v;
    byte_v = 8'hA5;
    rx[0]  = 1'b0;
    wait_cyc(Cpb);
    for (int i = 0; i < 4; i++) begin
      rx[0] = byte_v[i];
      wait_cyc(Cpb);
    end
    rst   = 1'b1;
    rx[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({dv, busy, perr, ferr, brk} !== 15'd0 || data0 !== 8'd0 || data1 !== 7'd0 ||
        data2 !== 8'd0)
      $display("FAIL mid_reset_outputs: got dv %b busy %b perr %b ferr %b brk %b data %h/%h/%h, required all 0",
               dv, busy, perr, ferr, brk, data0, data1, data2);
    else passes++;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(12 * Cpb);
    total++;
    if (obs_q.size() != 0 || busy[0] !== 1'b0) begin
      $display("FAIL mid_reset_after: got %0d DV busy %b, required 0 and 0", obs_q.size(), busy[0]);
      obs_q.delete();
    end else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity_7e2();
    test_frame_err_8o1();
    test_glitch();
    test_majority();
    test_back_to_back();
    test_break();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
